// File: rtl/ysyx_22050243_seq_ctrl.sv
// Multi-cycle sequencer for a simple RV core: fetch, decode, execute,
// optional data access, write-back. Every memory wait is bounded by
// TIMEOUT; expiry parks the core in HALT with err set. An ebreak parks
// it in HALT without error. Outputs are decoded from the registered state.
module ysyx_22050243_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic        reg_w,
  input  logic        csr_r,
  input  logic        is_ebreak,
  output logic        ifu_req,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_ready,
  input  logic        lsu_rvalid,
  output logic        ir_we,
  output logic        rf_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic [3:0]  state,
  output logic        halted,
  output logic        err,
  output logic [63:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_MWAIT  = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t        state_r, state_nxt_s;
  logic [15:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic [63:0]   instret_r, instret_nxt_s;
  logic [16:0]   cnt_inc_s;
  logic          timeout_hit_s;

  // States in which the wait counter runs against TIMEOUT.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MEM) || (s == S_MWAIT);
  endfunction

  // One more cycle without a handshake would reach the timeout limit.
  assign cnt_inc_s     = {1'b0, wait_cnt_r} + 17'd1;
  assign timeout_hit_s = (cnt_inc_s >= TIMEOUT_L);

  // State register plus wait counter, error flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 16'd0;
      err_r      <= 1'b0;
      instret_r  <= 64'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      err_r      <= err_nxt_s;
      instret_r  <= instret_nxt_s;
    end
  end

  // Next-state, timeout and retire bookkeeping; a completing handshake beats the timeout.
  always_comb begin
    state_nxt_s   = state_r;
    err_nxt_s     = err_r;
    instret_nxt_s = instret_r;
    case (state_r)
      S_IDLE:   state_nxt_s = S_FETCH;
      S_FETCH: begin
        if (ifu_ready) begin
          state_nxt_s = S_FWAIT;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_HALT;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_FWAIT: begin
        if (ifu_rvalid) begin
          state_nxt_s = S_DECODE;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_HALT;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_FWAIT;
        end
      end
      S_DECODE: state_nxt_s = is_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt_s = (mem_r | mem_w) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_ready) begin
          state_nxt_s = S_MWAIT;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_HALT;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_MWAIT: begin
        if (lsu_rvalid) begin
          state_nxt_s = S_WB;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_HALT;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_MWAIT;
        end
      end
      S_WB: begin
        state_nxt_s   = S_FETCH;
        instret_nxt_s = instret_r + 64'd1;
      end
      S_HALT:   state_nxt_s = S_HALT;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Wait counter restarts on entry to a wait state and counts while stuck there.
  always_comb begin
    if (is_wait_state(state_nxt_s) && (state_nxt_s != state_r)) begin
      wait_cnt_nxt_s = 16'd0;
    end else if (is_wait_state(state_r) && (state_nxt_s == state_r)) begin
      wait_cnt_nxt_s = wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // Output decode; IR capture coincides with the fetched word being valid.
  always_comb begin
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    csr_we  = 1'b0;
    pc_we   = 1'b0;
    case (state_r)
      S_FETCH: ifu_req = 1'b1;
      S_FWAIT: ir_we   = ifu_rvalid;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = mem_w;
      end
      S_WB: begin
        pc_we  = 1'b1;
        rf_we  = reg_w;
        csr_we = csr_r;
      end
      default: ifu_req = 1'b0;
    endcase
  end

  assign state   = state_r;
  assign halted  = (state_r == S_HALT);
  assign err     = err_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_ysyx_22050243_seq_ctrl.sv
// Self-checking bench for ysyx_22050243_seq_ctrl: a constant table for the
// zero-wait ALU loop, directed load/store/ebreak/timeout/reset sequences,
// and a randomized run against a behavioural model.
module tb_ysyx_22050243_seq_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r, mem_w, reg_w, csr_r, is_ebreak;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic        lsu_req, lsu_wen, lsu_ready, lsu_rvalid;
  logic        ir_we, rf_we, csr_we, pc_we;
  logic [3:0]  state;
  logic        halted, err;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase number as named in the state list, cycles waited, flags.
  int          m_state;
  int          m_wait;
  logic        m_err;
  logic [63:0] m_instret;

  always #5 clk = ~clk;

  ysyx_22050243_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_r(mem_r), .mem_w(mem_w), .reg_w(reg_w),
    .csr_r(csr_r), .is_ebreak(is_ebreak), .ifu_req(ifu_req), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid), .ir_we(ir_we), .rf_we(rf_we),
    .csr_we(csr_we), .pc_we(pc_we), .state(state), .halted(halted), .err(err),
    .instret(instret)
  );

  typedef struct {
    logic        reg_w;
    logic        csr_r;
    logic [3:0]  e_state;
    logic        e_ifu_req;
    logic        e_ir_we;
    logic        e_rf_we;
    logic        e_csr_we;
    logic        e_pc_we;
    logic [63:0] e_instret;
  } vec_t;

  function automatic vec_t mkv(input logic rw, cr, input logic [3:0] st,
                               input logic rq, ir, rf, cs, pc, input logic [63:0] ic);
    vec_t v;
    v.reg_w = rw; v.csr_r = cr; v.e_state = st; v.e_ifu_req = rq; v.e_ir_we = ir;
    v.e_rf_we = rf; v.e_csr_we = cs; v.e_pc_we = pc; v.e_instret = ic;
    return v;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_wait = 0; m_err = 1'b0; m_instret = 64'd0;
  endfunction

  function automatic bit is_wait(input int s);
    return (s == 1) || (s == 2) || (s == 5) || (s == 6);
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_step();
    int nxt;
    bit done;
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 3) nxt = is_ebreak ? 8 : 4;
    else if (m_state == 4) nxt = (mem_r || mem_w) ? 5 : 7;
    else if (m_state == 7) begin nxt = 1; m_instret = m_instret + 64'd1; end
    else if (m_state == 8) nxt = 8;
    else if (is_wait(m_state)) begin
      done = (m_state == 1 && ifu_ready) || (m_state == 2 && ifu_rvalid) ||
             (m_state == 5 && lsu_ready) || (m_state == 6 && lsu_rvalid);
      if (done) nxt = m_state + 1;
      else if (m_wait + 1 >= int'(TO)) begin nxt = 8; m_err = 1'b1; end
      else m_wait = m_wait + 1;
    end else nxt = 0;
    if (nxt != m_state && is_wait(nxt)) m_wait = 0;
    m_state = nxt;
  endfunction

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check(input string tag);
    logic [12:0] exp_v, got_v;
    exp_v = {4'(m_state), m_state == 1, m_state == 5, (m_state == 5) && mem_w,
             (m_state == 2) && ifu_rvalid, (m_state == 7) && reg_w,
             (m_state == 7) && csr_r, m_state == 7, m_state == 8, m_err};
    got_v = {state, ifu_req, lsu_req, lsu_wen, ir_we, rf_we, csr_we, pc_we, halted, err};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s outputs got=%b exp=%b t=%0t", tag, got_v, exp_v, $time);
    end
    check_val({tag, "_instret"}, instret, m_instret);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick(input string tag);
    #1;
    check(tag);
    advance();
  endtask

  task automatic clear_inputs();
    mem_r = 1'b0; mem_w = 1'b0; reg_w = 1'b0; csr_r = 1'b0; is_ebreak = 1'b0;
    ifu_ready = 1'b0; ifu_rvalid = 1'b0; lsu_ready = 1'b0; lsu_rvalid = 1'b0;
  endtask

  // Called one time unit after a rising edge; leaves reset released at the same phase.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic mem_instr(input logic r, w, rg, input int rdy_dly, vld_dly,
                           output int n_req, n_wen, n_wb, n_rf, n_pc);
    int mc, wc;
    bit seen_wb;
    mc = 0; wc = 0; seen_wb = 0;
    n_req = 0; n_wen = 0; n_wb = 0; n_rf = 0; n_pc = 0;
    mem_r = r; mem_w = w; reg_w = rg; csr_r = 1'b0; is_ebreak = 1'b0;
    ifu_ready = 1'b1; ifu_rvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (seen_wb && m_state != 7) break;
      lsu_ready  = (m_state == 5) && (mc >= rdy_dly);
      lsu_rvalid = (m_state == 6) && (wc >= vld_dly);
      #1;
      check("mem");
      if (lsu_req) n_req++;
      if (lsu_wen) n_wen++;
      if (state == 4'd7) n_wb++;
      if (rf_we) n_rf++;
      if (pc_we) n_pc++;
      if (m_state == 5) mc++;
      if (m_state == 6) wc++;
      if (m_state == 7) seen_wb = 1;
      advance();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[17];
    int n_req, n_wen, n_wb, n_rf, n_pc, cnt, halt_cyc;

    tbl[0]  = mkv(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tbl[1]  = mkv(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tbl[2]  = mkv(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    tbl[3]  = mkv(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tbl[4]  = mkv(1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tbl[5]  = mkv(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0);
    tbl[6]  = mkv(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1);
    tbl[7]  = mkv(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1);
    tbl[8]  = mkv(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1);
    tbl[9]  = mkv(1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1);
    tbl[10] = mkv(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1);
    tbl[11] = mkv(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2);
    tbl[12] = mkv(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd2);
    tbl[13] = mkv(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2);
    tbl[14] = mkv(1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2);
    tbl[15] = mkv(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd2);
    tbl[16] = mkv(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3);

    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // Zero-wait ALU loop against constant expectations.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      reg_w = tbl[i].reg_w; csr_r = tbl[i].csr_r;
      ifu_ready = 1'b1; ifu_rvalid = 1'b1;
      mem_r = 1'b0; mem_w = 1'b0; is_ebreak = 1'b0;
      #1;
      total++;
      if ({state, ifu_req, ir_we, rf_we, csr_we, pc_we} !==
          {tbl[i].e_state, tbl[i].e_ifu_req, tbl[i].e_ir_we, tbl[i].e_rf_we,
           tbl[i].e_csr_we, tbl[i].e_pc_we}) begin
        bad++;
        $display("FAIL alu_tbl[%0d] got st=%0d rq=%b ir=%b rf=%b csr=%b pc=%b exp st=%0d",
                 i, state, ifu_req, ir_we, rf_we, csr_we, pc_we, tbl[i].e_state);
      end
      check_val("alu_tbl_instret", instret, tbl[i].e_instret);
      @(posedge clk);
      #1;
    end

    // Load: lsu_ready after 3 wait cycles (lands on the timeout boundary), rvalid after 2.
    do_reset();
    mem_instr(1'b1, 1'b0, 1'b1, 3, 2, n_req, n_wen, n_wb, n_rf, n_pc);
    check_val("load_req_cycles", 64'(n_req), 64'd4);
    check_val("load_wen_cycles", 64'(n_wen), 64'd0);
    check_val("load_wb_cycles", 64'(n_wb), 64'd1);
    check_val("load_rf_we", 64'(n_rf), 64'd1);
    check_val("load_instret", instret, 64'd1);

    // Store with both mem_r and mem_w set: store wins, no register write.
    mem_instr(1'b1, 1'b1, 1'b0, 0, 0, n_req, n_wen, n_wb, n_rf, n_pc);
    check_val("store_wen_cycles", 64'(n_wen), 64'd1);
    check_val("store_rf_we", 64'(n_rf), 64'd0);
    check_val("store_pc_we", 64'(n_pc), 64'd1);
    check_val("store_instret", instret, 64'd2);

    // Reset during MWAIT clears everything asynchronously and restarts cleanly.
    mem_r = 1'b1; mem_w = 1'b0; reg_w = 1'b1; lsu_ready = 1'b1; lsu_rvalid = 1'b0;
    ifu_ready = 1'b1; ifu_rvalid = 1'b1;
    for (int c = 0; c < 20 && m_state != 6; c++) tick("to_mwait");
    tick("mwait");
    check_val("mwait_reached", 64'(state), 64'd6);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    check_val("async_rst_instret", instret, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("post_rst_idle");
    #1;
    check_val("post_rst_ifu_req", 64'(ifu_req), 64'd1);
    advance();

    // ebreak after one retired instruction: sticky halt, no fetches, instret frozen.
    do_reset();
    ifu_ready = 1'b1; ifu_rvalid = 1'b1; reg_w = 1'b1;
    for (int c = 0; c < 30 && m_state != 8; c++) begin
      is_ebreak = (m_instret != 64'd0);
      tick("to_ebreak");
    end
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      ifu_ready = 1'($urandom); ifu_rvalid = 1'($urandom); lsu_ready = 1'($urandom);
      #1;
      check("ebreak_halt");
      if (ifu_req) cnt++;
      advance();
    end
    check_val("ebreak_ifu_req_cnt", 64'(cnt), 64'd0);
    check_val("ebreak_state", 64'(state), 64'd8);
    check_val("ebreak_err", 64'(err), 64'd0);
    check_val("ebreak_instret", instret, 64'd1);

    // Fetch response never arrives: exactly TO cycles in FWAIT, then error halt.
    do_reset();
    ifu_ready = 1'b1; ifu_rvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && m_state != 8; c++) begin
      #1;
      check("fwait_to");
      if (state == 4'd2) cnt++;
      advance();
    end
    check_val("fwait_cycles", 64'(cnt), 64'(TO));
    check_val("timeout_err", 64'(err), 64'd1);
    ifu_rvalid = 1'b1;
    for (int c = 0; c < 5; c++) tick("halt_ignores_rvalid");
    check_val("timeout_sticky_state", 64'(state), 64'd8);

    // Randomized run against the model with occasional mid-cycle resets.
    do_reset();
    halt_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      ifu_ready  = ($urandom_range(0, 99) < 60);
      ifu_rvalid = ($urandom_range(0, 99) < 60);
      lsu_ready  = ($urandom_range(0, 99) < 60);
      lsu_rvalid = ($urandom_range(0, 99) < 60);
      mem_r      = ($urandom_range(0, 99) < 30);
      mem_w      = ($urandom_range(0, 99) < 20);
      reg_w      = ($urandom_range(0, 99) < 50);
      csr_r      = ($urandom_range(0, 99) < 30);
      is_ebreak  = ($urandom_range(0, 99) < 3);
      halt_cyc   = (m_state == 8) ? halt_cyc + 1 : 0;
      if (halt_cyc > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        halt_cyc = 0;
      end else begin
        tick("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
